muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide datapath, sitting beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time under a start/stall handshake and iterates a radix-2 shift-add multiplier or restoring divider over 32 cycles.
- Applies RV32M sign and special-case rules, then presents a registered 32-bit result with a one-cycle done pulse.
- Holds the pipeline via stall until the result is ready.

---
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the execute stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Pipeline side: issues operations, observes progress and result.
  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  busy_o, stall_o, done_o, result_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
    output busy_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: radix-2 shift-add multiply and restoring divide,
// 32 iterations, with RV32M sign handling and divide special cases.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned      ACC_W     = 2 * XLEN;
  localparam int unsigned      CNT_W     = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [XLEN-1:0]  result_q;

  logic             is_div;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic [XLEN-1:0]  special_res;
  logic [XLEN:0]    mul_sum;
  logic [ACC_W-1:0] mul_next;
  logic [XLEN:0]    rem_sh;
  logic             rem_ge;
  logic [XLEN-1:0]  rem_diff;
  logic [ACC_W-1:0] div_next;
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  fix_res;

  // Operand conditioning, one datapath iteration and final sign fix-up.
  always_comb begin
    is_div   = funct3_q[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_q)
      F_MULH, F_DIV, F_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed & a_q[XLEN-1];
    b_neg = b_signed & b_q[XLEN-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;

    div_zero    = (b_q == '0);
    div_ovf     = is_div & ~funct3_q[0] & (a_q == INT_MIN) & (b_q == '1);
    special_res = div_zero ? (funct3_q[1] ? a_q : '1)
                           : (funct3_q[1] ? '0 : INT_MIN);

    // Multiply: low half holds the multiplier, multiplicand in a_q.
    mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {remainder, quotient}, divisor in b_q.
    rem_sh   = acc_q[ACC_W-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_diff = rem_sh[XLEN-1:0] - b_q;
    div_next = rem_ge ? {rem_diff, acc_q[XLEN-2:0], 1'b1}
                      : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    prod    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo     = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = neg_a_q ? -acc_q[ACC_W-1:XLEN] : acc_q[ACC_W-1:XLEN];
    fix_res = is_div ? (funct3_q[1] ? rem : quo)
                     : ((funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN]);
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= S_IDLE;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush_i) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            funct3_q <= bus.funct3_i;
            a_q      <= bus.op_a_i;
            b_q      <= bus.op_b_i;
            busy_q   <= 1'b1;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          neg_a_q <= a_neg;
          neg_b_q <= b_neg;
          a_q     <= a_mag;
          b_q     <= b_mag;
          cnt_q   <= '0;
          acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          if (is_div && (div_zero || div_ovf)) begin
            result_q <= special_res;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= is_div ? div_next : mul_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline from the issuing cycle until the result is ready.
  always_comb begin
    bus.stall_o = ((state == S_IDLE) & bus.start_i & ~bus.flush_i)
                | (state == S_PREP) | (state == S_CALC) | (state == S_FIX);
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bit          stall_log [0:99];
  bit          busy_log  [0:99];
  bit          done_log  [0:99];
  logic [31:0] res_log   [0:99];

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RV32M reference computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      MUL:    begin p = ua * ub; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int expected_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 35;
  endfunction

  // Drive one start (optionally held) and log outputs per cycle; cycle 0 is the start cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input int flush_at, input int ncyc,
                        output int done_cyc, output int done_cnt);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = f3;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.flush_i  = (flush_at == 0);
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      stall_log[c] = bus.stall_o;
      busy_log[c]  = bus.busy_o;
      done_log[c]  = bus.done_o;
      res_log[c]   = bus.result_o;
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(negedge clk);
      if (!hold) bus.start_i = 1'b0;
      bus.flush_i = (c + 1 == flush_at);
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy_o); end
    n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done_o); end
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", bus.stall_o); end
    n_tests++; if (bus.result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result_o); end
  endtask

  task automatic test_mul_basic;
    int dc, dn, bad;
    run_op(MUL, 32'd7, 32'hFFFF_FFFD, 1'b0, -1, 38, dc, dn);
    n_tests++; if (dc !== 35 || dn !== 1) begin n_fail++; $display("FAIL mul_done_cycle got %0d (count %0d) want 35 (1)", dc, dn); end
    n_tests++; if (res_log[35] !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", res_log[35]); end
    bad = 0;
    for (int c = 0; c <= 34; c++) if (stall_log[c] !== 1'b1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mul_stall_window got %0d low cycles want 0", bad); end
    n_tests++; if (stall_log[35] !== 1'b0) begin n_fail++; $display("FAIL mul_stall_done got %0b want 0", stall_log[35]); end
    n_tests++; if (busy_log[35] !== 1'b1 || busy_log[36] !== 1'b0) begin n_fail++; $display("FAIL mul_busy got %0b/%0b want 1/0", busy_log[35], busy_log[36]); end
    n_tests++; if (res_log[37] !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result_hold got %h want ffffffeb", res_log[37]); end
  endtask

  task automatic test_mul_high;
    logic [2:0]  ops  [3] = '{MULH, MULHU, MULHSU};
    logic [31:0] want [3] = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
    int dc, dn;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'h8000_0000, 32'h8000_0000, 1'b0, -1, 37, dc, dn);
      n_tests++;
      if (dc !== 35 || res_log[35] !== want[i]) begin
        n_fail++; $display("FAIL mulhigh_f3_%0d got %h at cycle %0d want %h at 35", ops[i], res_log[35], dc, want[i]);
      end
    end
  endtask

  task automatic test_div_rem;
    logic [2:0]  ops  [3] = '{DIV, REM, DIVU};
    logic [31:0] want [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    int dc, dn;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'hFFFF_FFF9, 32'd2, 1'b0, -1, 37, dc, dn);
      n_tests++;
      if (dc !== 35 || res_log[35] !== want[i]) begin
        n_fail++; $display("FAIL divrem_f3_%0d got %h at cycle %0d want %h at 35", ops[i], res_log[35], dc, want[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops  [4] = '{DIVU, REMU, DIV, REM};
    logic [31:0] av   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int dc, dn;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], 1'b0, -1, 6, dc, dn);
      n_tests++;
      if (dc !== 2 || dn !== 1 || res_log[2] !== want[i]) begin
        n_fail++; $display("FAIL special_%0d got %h at cycle %0d want %h at 2", i, res_log[2], dc, want[i]);
      end
      n_tests++; if (stall_log[2] !== 1'b0 || busy_log[3] !== 1'b0) begin n_fail++; $display("FAIL special_%0d_idle stall %0b busy %0b want 0 0", i, stall_log[2], busy_log[3]); end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random;
    int dc, dn, lat;
    logic [2:0]  f3;
    logic [31:0] a, b, want;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      want = model(f3, a, b);
      lat  = expected_latency(f3, a, b);
      run_op(f3, a, b, 1'b0, -1, lat + 2, dc, dn);
      n_tests++;
      if (dc !== lat || dn !== 1 || res_log[lat] !== want) begin
        n_fail++; $display("FAIL random_%0d f3=%0d a=%h b=%h got %h at cycle %0d want %h at %0d", i, f3, a, b, res_log[lat], dc, want, lat);
      end
    end
  endtask

  task automatic test_flush;
    int dc, dn, bad;
    run_op(DIVU, 32'd100, 32'd7, 1'b0, -1, 37, dc, dn);
    n_tests++; if (res_log[35] !== 32'd14) begin n_fail++; $display("FAIL flush_prime got %h want 0000000e", res_log[35]); end
    run_op(DIV, 32'd1000, 32'd3, 1'b0, 10, 40, dc, dn);
    n_tests++; if (busy_log[10] !== 1'b1 || busy_log[11] !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy %0b/%0b want 1/0", busy_log[10], busy_log[11]); end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", dn); end
    bad = 0;
    for (int c = 0; c < 40; c++) if (res_log[c] !== 32'd14) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL flush_result_kept got %0d changed cycles want 0", bad); end
    run_op(MUL, 32'd5, 32'd5, 1'b0, 0, 8, dc, dn);
    n_tests++; if (busy_log[1] !== 1'b0 || dn !== 0 || stall_log[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_over_start busy %0b done %0d stall %0b want 0 0 0", busy_log[1], dn, stall_log[0]);
    end
  endtask

  task automatic test_reset_mid;
    int dc, dn, cnt;
    run_op(MULHU, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, 37, dc, dn);
    n_tests++; if (res_log[35] !== 32'h4000_0000) begin n_fail++; $display("FAIL rst_prime got %h want 40000000", res_log[35]); end
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = MUL; bus.op_a_i = 32'd9; bus.op_b_i = 32'd9;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy_o !== 1'b0 || bus.result_o !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid busy %0b result %h want 0 0", bus.busy_o, bus.result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      #1;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) cnt++;
      @(negedge clk);
    end
    n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL rst_no_done got %0d active cycles want 0", cnt); end
    run_op(MUL, 32'd3, 32'd4, 1'b0, -1, 37, dc, dn);
    n_tests++; if (dc !== 35 || res_log[35] !== 32'd12) begin n_fail++; $display("FAIL rst_then_mul got %h at cycle %0d want 0000000c at 35", res_log[35], dc); end
  endtask

  task automatic test_back_to_back;
    int dc, dn;
    logic [31:0] want;
    want = model(MUL, 32'h1234_5678, 32'h9ABC_DEF1);
    run_op(MUL, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1, -1, 72, dc, dn);
    n_tests++; if (dc !== 35 || dn !== 2 || done_log[71] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done first %0d count %0d last %0b want 35 2 1", dc, dn, done_log[71]);
    end
    n_tests++; if (busy_log[36] !== 1'b0 || stall_log[36] !== 1'b1 || busy_log[37] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept busy36 %0b stall36 %0b busy37 %0b want 0 1 1", busy_log[36], stall_log[36], busy_log[37]);
    end
    n_tests++; if (res_log[35] !== want || res_log[71] !== want) begin
      n_fail++; $display("FAIL b2b_result got %h/%h want %h", res_log[35], res_log[71], want);
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_final_idle busy %0b want 0", bus.busy_o); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.start_i  = 1'b0;
    bus.funct3_i = 3'd0;
    bus.op_a_i   = 32'd0;
    bus.op_b_i   = 32'd0;
    bus.flush_i  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_mul_basic;
    test_mul_high;
    test_div_rem;
    test_special;
    test_random;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
